// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the 32-bit bus datapath.
// Sequences fetch/decode/execute and drives every datapath strobe.
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        conOut,
    input  logic        stop,
    output logic        run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Yin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        IncPC,
    output logic        Cout,
    output logic        R8_RAin,
    output logic        conIn,
    output logic        Out_portIn,
    output logic        InPortout,
    output logic        read,
    output logic        write,
    output logic [4:0]  opcode
);

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_PAUSE = 4'd9;
    localparam logic [3:0] S_HALT  = 4'd10;

    localparam logic [27:0] M_GRA   = 28'd1 << 0;
    localparam logic [27:0] M_GRB   = 28'd1 << 1;
    localparam logic [27:0] M_GRC   = 28'd1 << 2;
    localparam logic [27:0] M_RIN   = 28'd1 << 3;
    localparam logic [27:0] M_ROUT  = 28'd1 << 4;
    localparam logic [27:0] M_BAOUT = 28'd1 << 5;
    localparam logic [27:0] M_HIIN  = 28'd1 << 6;
    localparam logic [27:0] M_HIOUT = 28'd1 << 7;
    localparam logic [27:0] M_LOIN  = 28'd1 << 8;
    localparam logic [27:0] M_LOOUT = 28'd1 << 9;
    localparam logic [27:0] M_ZIN   = 28'd1 << 10;
    localparam logic [27:0] M_ZHI   = 28'd1 << 11;
    localparam logic [27:0] M_ZLO   = 28'd1 << 12;
    localparam logic [27:0] M_YIN   = 28'd1 << 13;
    localparam logic [27:0] M_MDRIN = 28'd1 << 14;
    localparam logic [27:0] M_MDROUT = 28'd1 << 15;
    localparam logic [27:0] M_MARIN = 28'd1 << 16;
    localparam logic [27:0] M_PCIN  = 28'd1 << 17;
    localparam logic [27:0] M_PCOUT = 28'd1 << 18;
    localparam logic [27:0] M_IRIN  = 28'd1 << 19;
    localparam logic [27:0] M_INCPC = 28'd1 << 20;
    localparam logic [27:0] M_COUT  = 28'd1 << 21;
    localparam logic [27:0] M_R8    = 28'd1 << 22;
    localparam logic [27:0] M_CONIN = 28'd1 << 23;
    localparam logic [27:0] M_OPIN  = 28'd1 << 24;
    localparam logic [27:0] M_INPO  = 28'd1 << 25;
    localparam logic [27:0] M_READ  = 28'd1 << 26;
    localparam logic [27:0] M_WRITE = 28'd1 << 27;

    logic [3:0]  state_q, state_d;
    logic [3:0]  last_s, t0_s;
    logic [4:0]  op, alu_c;
    logic [27:0] ctl, ctl_g;
    logic        ir_unused;

    logic is_ld, is_ldi, is_st, is_mem, is_r, is_imm, is_md, is_un;
    logic is_br, is_jal, is_jr, is_in, is_out, is_mflo, is_mfhi, is_halt;

    assign op        = ir[31:27];
    assign ir_unused = ^ir[26:0];

    assign is_ld   = (op == 5'd0);
    assign is_ldi  = (op == 5'd1);
    assign is_st   = (op == 5'd2);
    assign is_mem  = is_ld | is_ldi | is_st;
    assign is_r    = (op >= 5'd3) && (op <= 5'd11);
    assign is_imm  = (op >= 5'd12) && (op <= 5'd14);
    assign is_md   = (op == 5'd15) || (op == 5'd16);
    assign is_un   = (op == 5'd17) || (op == 5'd18);
    assign is_br   = (op == 5'd19);
    assign is_jal  = (op == 5'd20);
    assign is_jr   = (op == 5'd21);
    assign is_in   = (op == 5'd22);
    assign is_out  = (op == 5'd23);
    assign is_mflo = (op == 5'd24);
    assign is_mfhi = (op == 5'd25);
    assign is_halt = (op == 5'd27);

    // Instruction boundary honours a pending pause request.
    assign t0_s = stop ? S_PAUSE : S_T0;

    // Final execute step of the current instruction; st idles in T7 so
    // both memory ops share the same 8-cycle length.
    always_comb begin
        last_s = S_T3;
        unique case (1'b1)
            is_ld, is_st:         last_s = S_T7;
            is_md, is_br:         last_s = S_T6;
            is_ldi, is_r, is_imm: last_s = S_T5;
            is_un, is_jal:        last_s = S_T4;
            default:              last_s = S_T3;
        endcase
    end

    // Next-state sequencing; clear wins from any state.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_RESET;
        end else begin
            unique case (state_q)
                S_RESET: state_d = t0_s;
                S_T0:    state_d = S_T1;
                S_T1:    state_d = S_T2;
                S_T2:    state_d = S_T3;
                S_T3, S_T4, S_T5, S_T6, S_T7: begin
                    if (state_q == last_s)
                        state_d = is_halt ? S_HALT : t0_s;
                    else
                        state_d = state_q + 4'd1;
                end
                S_PAUSE: state_d = stop ? S_PAUSE : S_T0;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_RESET;
            endcase
        end
    end

    // State register with synchronous active-high clear.
    always_ff @(posedge clock) begin
        if (clear)
            state_q <= S_RESET;
        else
            state_q <= state_d;
    end

    // Moore strobe decode; the ALU op is presented in the step that loads Z.
    always_comb begin
        ctl   = '0;
        alu_c = '0;
        unique case (state_q)
            S_T0: ctl = M_PCOUT | M_MARIN | M_INCPC;
            S_T1: ctl = M_READ | M_MDRIN;
            S_T2: ctl = M_MDROUT | M_IRIN;
            S_T3: begin
                unique case (1'b1)
                    is_mem:        ctl = M_GRB | M_BAOUT | M_YIN;
                    is_r, is_imm:  ctl = M_GRB | M_ROUT | M_YIN;
                    is_md:         ctl = M_GRA | M_ROUT | M_YIN;
                    is_un: begin
                        ctl   = M_GRB | M_ROUT | M_ZIN;
                        alu_c = op;
                    end
                    is_br:   ctl = M_GRA | M_ROUT | M_CONIN;
                    is_jal:  ctl = M_PCOUT | M_R8;
                    is_jr:   ctl = M_GRA | M_ROUT | M_PCIN;
                    is_in:   ctl = M_INPO | M_GRA | M_RIN;
                    is_out:  ctl = M_GRA | M_ROUT | M_OPIN;
                    is_mflo: ctl = M_LOOUT | M_GRA | M_RIN;
                    is_mfhi: ctl = M_HIOUT | M_GRA | M_RIN;
                    default: ctl = '0;
                endcase
            end
            S_T4: begin
                unique case (1'b1)
                    is_mem: begin
                        ctl   = M_COUT | M_ZIN;
                        alu_c = ADD_OP;
                    end
                    is_r: begin
                        ctl   = M_GRC | M_ROUT | M_ZIN;
                        alu_c = op;
                    end
                    is_imm: begin
                        ctl   = M_COUT | M_ZIN;
                        alu_c = op;
                    end
                    is_md: begin
                        ctl   = M_GRB | M_ROUT | M_ZIN;
                        alu_c = op;
                    end
                    is_un:   ctl = M_ZLO | M_GRA | M_RIN;
                    is_br:   ctl = M_PCOUT | M_YIN;
                    is_jal:  ctl = M_GRA | M_ROUT | M_PCIN;
                    default: ctl = '0;
                endcase
            end
            S_T5: begin
                unique case (1'b1)
                    is_ld, is_st:         ctl = M_ZLO | M_MARIN;
                    is_ldi, is_r, is_imm: ctl = M_ZLO | M_GRA | M_RIN;
                    is_md:                ctl = M_ZLO | M_LOIN;
                    is_br: begin
                        ctl   = M_COUT | M_ZIN;
                        alu_c = ADD_OP;
                    end
                    default: ctl = '0;
                endcase
            end
            S_T6: begin
                unique case (1'b1)
                    is_ld:   ctl = M_READ | M_MDRIN;
                    is_st:   ctl = M_GRA | M_ROUT | M_MDRIN | M_WRITE;
                    is_md:   ctl = M_ZHI | M_HIIN;
                    is_br:   ctl = conOut ? (M_ZLO | M_PCIN) : '0;
                    default: ctl = '0;
                endcase
            end
            S_T7: ctl = is_ld ? (M_MDROUT | M_GRA | M_RIN) : '0;
            default: ctl = '0;
        endcase
    end

    assign ctl_g  = clear ? '0 : ctl;
    assign opcode = clear ? 5'd0 : alu_c;
    assign run    = !clear && (state_q >= S_T0) && (state_q <= S_T7);

    assign Gra        = ctl_g[0];
    assign Grb        = ctl_g[1];
    assign Grc        = ctl_g[2];
    assign Rin        = ctl_g[3];
    assign Rout       = ctl_g[4];
    assign BAout      = ctl_g[5];
    assign HIin       = ctl_g[6];
    assign HIout      = ctl_g[7];
    assign LOin       = ctl_g[8];
    assign LOout      = ctl_g[9];
    assign Zin        = ctl_g[10];
    assign Zhighout   = ctl_g[11];
    assign Zlowout    = ctl_g[12];
    assign Yin        = ctl_g[13];
    assign MDRin      = ctl_g[14];
    assign MDRout     = ctl_g[15];
    assign MARin      = ctl_g[16];
    assign PCin       = ctl_g[17];
    assign PCout      = ctl_g[18];
    assign IRin       = ctl_g[19];
    assign IncPC      = ctl_g[20];
    assign Cout       = ctl_g[21];
    assign R8_RAin    = ctl_g[22];
    assign conIn      = ctl_g[23];
    assign Out_portIn = ctl_g[24];
    assign InPortout  = ctl_g[25];
    assign read       = ctl_g[26];
    assign write      = ctl_g[27];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instruction streams
// checked cycle by cycle against a queue-based step model.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = '0;
    logic        conOut = 1'b0;
    logic        stop = 1'b0;
    logic run, Gra, Grb, Grc, Rin, Rout, BAout, HIin, HIout, LOin, LOout;
    logic Zin, Zhighout, Zlowout, Yin, MDRin, MDRout, MARin, PCin, PCout;
    logic IRin, IncPC, Cout, R8_RAin, conIn, Out_portIn, InPortout;
    logic read, write;
    logic [4:0] opcode;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .conOut(conOut),
        .stop(stop), .run(run), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .HIin(HIin),
        .HIout(HIout), .LOin(LOin), .LOout(LOout), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Yin(Yin),
        .MDRin(MDRin), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
        .PCout(PCout), .IRin(IRin), .IncPC(IncPC), .Cout(Cout),
        .R8_RAin(R8_RAin), .conIn(conIn), .Out_portIn(Out_portIn),
        .InPortout(InPortout), .read(read), .write(write),
        .opcode(opcode)
    );

    typedef logic [27:0] strb_t;
    localparam strb_t GRA = 28'd1 << 0,  GRB = 28'd1 << 1;
    localparam strb_t GRC = 28'd1 << 2,  RIN = 28'd1 << 3;
    localparam strb_t ROUT = 28'd1 << 4, BAOUT = 28'd1 << 5;
    localparam strb_t HIIN = 28'd1 << 6, HIOUT = 28'd1 << 7;
    localparam strb_t LOIN = 28'd1 << 8, LOOUT = 28'd1 << 9;
    localparam strb_t ZIN = 28'd1 << 10, ZHI = 28'd1 << 11;
    localparam strb_t ZLO = 28'd1 << 12, YIN = 28'd1 << 13;
    localparam strb_t MDRIN = 28'd1 << 14, MDROUT = 28'd1 << 15;
    localparam strb_t MARIN = 28'd1 << 16, PCIN = 28'd1 << 17;
    localparam strb_t PCOUT = 28'd1 << 18, IRIN = 28'd1 << 19;
    localparam strb_t INCPC = 28'd1 << 20, COUT = 28'd1 << 21;
    localparam strb_t R8 = 28'd1 << 22, CONIN = 28'd1 << 23;
    localparam strb_t OPIN = 28'd1 << 24, INPO = 28'd1 << 25;
    localparam strb_t READ = 28'd1 << 26, WRITE = 28'd1 << 27;
    localparam strb_t BUSDRV = HIOUT | LOOUT | ZHI | ZLO | MDROUT |
                               PCOUT | INPO | ROUT | BAOUT | COUT;
    localparam logic [4:0] ADD = 5'b00011;

    logic [33:0] obs;
    assign obs = {run, opcode, write, read, InPortout, Out_portIn,
                  conIn, R8_RAin, Cout, IncPC, IRin, PCout, PCin, MARin,
                  MDRout, MDRin, Yin, Zlowout, Zhighout, Zin, LOout, LOin,
                  HIout, HIin, BAout, Rout, Rin, Grc, Grb, Gra};

    localparam int M_RESET = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;
    int          mode = M_RESET;
    int          m_idx = 0;
    bit          m_halt = 0;
    logic [33:0] q[$];
    int          n_checks = 0;
    int          n_err = 0;

    function automatic logic [33:0] V(strb_t s, logic [4:0] op = 5'd0);
        return {1'b1, op, s};
    endfunction

    // Execute steps for one instruction, straight from the opcode table.
    function automatic void push_exec(logic [4:0] op, logic con);
        if (op == 5'd0) begin
            q.push_back(V(GRB | BAOUT | YIN));
            q.push_back(V(COUT | ZIN, ADD));
            q.push_back(V(ZLO | MARIN));
            q.push_back(V(READ | MDRIN));
            q.push_back(V(MDROUT | GRA | RIN));
        end else if (op == 5'd1) begin
            q.push_back(V(GRB | BAOUT | YIN));
            q.push_back(V(COUT | ZIN, ADD));
            q.push_back(V(ZLO | GRA | RIN));
        end else if (op == 5'd2) begin
            q.push_back(V(GRB | BAOUT | YIN));
            q.push_back(V(COUT | ZIN, ADD));
            q.push_back(V(ZLO | MARIN));
            q.push_back(V(GRA | ROUT | MDRIN | WRITE));
            q.push_back(V('0));
        end else if (op <= 5'd11) begin
            q.push_back(V(GRB | ROUT | YIN));
            q.push_back(V(GRC | ROUT | ZIN, op));
            q.push_back(V(ZLO | GRA | RIN));
        end else if (op <= 5'd14) begin
            q.push_back(V(GRB | ROUT | YIN));
            q.push_back(V(COUT | ZIN, op));
            q.push_back(V(ZLO | GRA | RIN));
        end else if (op <= 5'd16) begin
            q.push_back(V(GRA | ROUT | YIN));
            q.push_back(V(GRB | ROUT | ZIN, op));
            q.push_back(V(ZLO | LOIN));
            q.push_back(V(ZHI | HIIN));
        end else if (op <= 5'd18) begin
            q.push_back(V(GRB | ROUT | ZIN, op));
            q.push_back(V(ZLO | GRA | RIN));
        end else if (op == 5'd19) begin
            q.push_back(V(GRA | ROUT | CONIN));
            q.push_back(V(PCOUT | YIN));
            q.push_back(V(COUT | ZIN, ADD));
            q.push_back(V(con ? (ZLO | PCIN) : '0));
        end else if (op == 5'd20) begin
            q.push_back(V(PCOUT | R8));
            q.push_back(V(GRA | ROUT | PCIN));
        end else if (op == 5'd21) q.push_back(V(GRA | ROUT | PCIN));
        else if (op == 5'd22) q.push_back(V(INPO | GRA | RIN));
        else if (op == 5'd23) q.push_back(V(GRA | ROUT | OPIN));
        else if (op == 5'd24) q.push_back(V(LOOUT | GRA | RIN));
        else if (op == 5'd25) q.push_back(V(HIOUT | GRA | RIN));
        else begin
            q.push_back(V('0));
            if (op == 5'd27) m_halt = 1;
        end
    endfunction

    function automatic void enter_t0();
        m_halt = 0;
        m_idx = 0;
        q.delete();
        if (stop) mode = M_PAUSE;
        else begin
            mode = M_RUN;
            q.push_back(V(PCOUT | MARIN | INCPC));
            q.push_back(V(READ | MDRIN));
            q.push_back(V(MDROUT | IRIN));
        end
    endfunction

    function automatic void model_tick();
        if (clear) begin
            mode = M_RESET;
            q.delete();
            m_halt = 0;
        end else if (mode == M_RESET) enter_t0();
        else if (mode == M_PAUSE) begin
            if (!stop) enter_t0();
        end else if (mode == M_RUN) begin
            void'(q.pop_front());
            m_idx++;
            if (m_idx == 3) push_exec(ir[31:27], conOut);
            if (q.size() == 0) begin
                if (m_halt) mode = M_HALT;
                else enter_t0();
            end
        end
    endfunction

    function automatic logic [33:0] expected();
        if (clear) return '0;
        if (mode == M_RUN && q.size() > 0) return q[0];
        return '0;
    endfunction

    task automatic step(string tag);
        logic [33:0] e;
        #1;
        e = expected();
        n_checks++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
        n_checks++;
        assert ($countones(obs[27:0] & BUSDRV) <= 1) else begin
            n_err++;
            $error("FAIL %s_bus: observed drivers %h expected at most one",
                   tag, obs[27:0] & BUSDRV);
        end
        model_tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(logic [31:0] iv, logic con, logic stp,
                             string tag);
        bit done;
        done = 0;
        ir = iv;
        conOut = con;
        stop = stp;
        for (int k = 0; k < 12; k++) begin
            step(tag);
            if (mode != M_RUN || m_idx == 0) begin
                done = 1;
                break;
            end
        end
        n_checks++;
        assert (done) else begin
            n_err++;
            $error("FAIL %s_timeout: observed no boundary expected one", tag);
        end
        if (mode == M_PAUSE) begin
            repeat (1 + $urandom % 3) step({tag, "_pause"});
            stop = 0;
            step({tag, "_resume"});
        end
    endtask

    initial begin
        logic [4:0] op;
        step("reset_hold");
        step("reset_hold");
        clear = 0;
        step("reset_state");
        #1;
        n_checks++;
        assert (obs === {1'b1, 5'd0, PCOUT | MARIN | INCPC}) else begin
            n_err++;
            $error("FAIL t0_after_reset: observed %h expected %h", obs,
                   {1'b1, 5'd0, PCOUT | MARIN | INCPC});
        end

        run_instr(32'h1800_0000, 1'b0, 1'b0, "add");
        run_instr(32'h0080_0005, 1'b0, 1'b0, "ld");
        run_instr({5'd19, 27'($urandom)}, 1'b0, 1'b0, "br_nt");
        run_instr({5'd19, 27'($urandom)}, 1'b1, 1'b0, "br_t");
        run_instr({5'd2, 27'($urandom)}, 1'b0, 1'b1, "st_stop");

        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr({op, 27'($urandom)}, 1'($urandom % 2),
                      ($urandom % 8) == 0, "rand");
        end

        ir = {5'd16, 27'($urandom)};
        stop = 0;
        repeat (4) step("mul");
        clear = 1;
        step("mul_clear");
        clear = 0;
        step("mul_reset");

        clear = 1;
        step("pause_clear");
        clear = 0;
        stop = 1;
        step("pause_entry");
        repeat (3) step("pause_hold");
        stop = 0;
        step("pause_exit");

        run_instr(32'hD800_0000, 1'b0, 1'b0, "halt");
        repeat (20) step("halt_hold");
        clear = 1;
        step("halt_clear");
        clear = 0;
        step("halt_reset");
        run_instr(32'h1800_0000, 1'b0, 1'b0, "add_after_halt");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
